// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the 7-segment scan controller.
//   - glyph codes for the non-numeric symbols carried on the display bus
//   - 7-bit segment patterns, bit order {g,f,e,d,c,b,a}
package seg_pkg;

  typedef logic [6:0] seg7_t;

  localparam logic [3:0] GLY_U     = 4'hA;
  localparam logic [3:0] GLY_D     = 4'hB;
  localparam logic [3:0] GLY_DASH  = 4'hC;
  localparam logic [3:0] GLY_OPEN  = 4'hD;
  localparam logic [3:0] GLY_CLOSE = 4'hE;
  localparam logic [3:0] GLY_BAR   = 4'hF;

  localparam seg7_t SEG_0     = 7'b0111111;
  localparam seg7_t SEG_1     = 7'b0000110;
  localparam seg7_t SEG_2     = 7'b1011011;
  localparam seg7_t SEG_3     = 7'b1001111;
  localparam seg7_t SEG_4     = 7'b1100110;
  localparam seg7_t SEG_5     = 7'b1101101;
  localparam seg7_t SEG_6     = 7'b1111101;
  localparam seg7_t SEG_7     = 7'b0000111;
  localparam seg7_t SEG_8     = 7'b1111111;
  localparam seg7_t SEG_9     = 7'b1101111;
  localparam seg7_t SEG_U     = 7'b0111110;
  localparam seg7_t SEG_D     = 7'b1011110;
  localparam seg7_t SEG_DASH  = 7'b1000000;
  localparam seg7_t SEG_OPEN  = 7'b1110011;  // "P"
  localparam seg7_t SEG_CLOSE = 7'b0111001;  // "C"
  localparam seg7_t SEG_BAR   = 7'b0001000;  // "_"

endpackage

// File: rtl/seg_glyph_dec.sv
// seg_glyph_dec: combinational glyph decoder.
//   code    in  4  glyph code (0-9 digits, A-F symbols from seg_pkg)
//   pattern out 7  segment pattern {g,f,e,d,c,b,a}, logical 1 = segment on
module seg_glyph_dec
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output seg7_t      pattern
);

  always_comb begin
    pattern = '0;
    case (code)
      4'd0:      pattern = SEG_0;
      4'd1:      pattern = SEG_1;
      4'd2:      pattern = SEG_2;
      4'd3:      pattern = SEG_3;
      4'd4:      pattern = SEG_4;
      4'd5:      pattern = SEG_5;
      4'd6:      pattern = SEG_6;
      4'd7:      pattern = SEG_7;
      4'd8:      pattern = SEG_8;
      4'd9:      pattern = SEG_9;
      GLY_U:     pattern = SEG_U;
      GLY_D:     pattern = SEG_D;
      GLY_DASH:  pattern = SEG_DASH;
      GLY_OPEN:  pattern = SEG_OPEN;
      GLY_CLOSE: pattern = SEG_CLOSE;
      GLY_BAR:   pattern = SEG_BAR;
      default:   pattern = '0;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scan controller.
// Scans NUM_DIGITS common-select lines over one shared segment bus. Inputs are
// snapshotted once per frame so a frame is never torn; each digit slot has a
// one-clock dark gap at its start and is PWM-dimmed by the brightness code.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   data_bus      4-bit glyph code per digit, digit i = data_bus[4i+3:4i]
//   dp_mask       per-digit decimal point
//   blank_mask    per-digit blank (1 = dark)
//   brightness    duty code, 0 = 1/2**BRIGHT_W ... max = full on
//   blink_mask    per-digit blink enable (only with SEG_BLINK_EN)
//   pos           one-hot digit select at the pins
//   seg           segments {dp,g,f,e,d,c,b,a} at the pins
//   frame_start   high in the cycle a new snapshot is captured
//
// Build option: define SEG_BLINK_EN to add blink_mask and the blink frame counter.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 262144,
  parameter int BRIGHT_W     = 3,
  parameter bit ACTIVE_LOW   = 1'b0,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_bus,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [BRIGHT_W-1:0]     brightness,
`ifdef SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [NUM_DIGITS-1:0]   pos,
  output logic [7:0]              seg,
  output logic                    frame_start
);

  localparam int SUB_LEN = SCAN_DIV >> BRIGHT_W;
  localparam int TICK_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int SUB_W   = (SUB_LEN > 2) ? $clog2(SUB_LEN) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(SUB_LEN - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  if ((SCAN_DIV % (1 << BRIGHT_W)) != 0) begin : g_err_div
    $error("seg_scan_ctrl: SCAN_DIV must be a multiple of 2**BRIGHT_W");
  end
  if (SUB_LEN < 2) begin : g_err_sub
    $error("seg_scan_ctrl: SCAN_DIV >> BRIGHT_W must be at least 2");
  end
  if (NUM_DIGITS < 1) begin : g_err_dig
    $error("seg_scan_ctrl: NUM_DIGITS must be at least 1");
  end
  if (BLINK_FRAMES < 1) begin : g_err_blink
    $error("seg_scan_ctrl: BLINK_FRAMES must be at least 1");
  end

  logic [TICK_W-1:0]       tick_cnt_q, tick_cnt_d;
  logic [SUB_W-1:0]        sub_tick_q, sub_tick_d;
  logic [BRIGHT_W-1:0]     sub_idx_q, sub_idx_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    load_pending_q, load_pending_d;
  logic [4*NUM_DIGITS-1:0] code_snap_q, code_snap_d;
  logic [NUM_DIGITS-1:0]   dp_snap_q, dp_snap_d;
  logic [NUM_DIGITS-1:0]   blank_snap_q, blank_snap_d;
  logic [BRIGHT_W-1:0]     bright_snap_q, bright_snap_d;
  logic [NUM_DIGITS-1:0]   pos_q, pos_d;
  logic [7:0]              seg_q, seg_d;

  logic  slot_end;
  logic  frame_bnd;
  logic  snap_en;
  logic  lit;
  logic  blink_sup;
  logic [3:0] code_sel;
  seg7_t glyph_pat;

  always_comb begin
    slot_end  = (tick_cnt_q == TICK_LAST);
    frame_bnd = slot_end && (idx_q == IDX_LAST);
    snap_en   = load_pending_q || frame_bnd;
  end

  // Masked with rst so the pulse stays low while reset is held even though
  // load_pending is already set.
  assign frame_start = snap_en && !rst;

  // Prescaler: sub_idx tracks tick_cnt / SUB_LEN with its own sub-counter.
  always_comb begin
    tick_cnt_d = slot_end ? '0 : tick_cnt_q + TICK_W'(1);
    sub_tick_d = sub_tick_q;
    sub_idx_d  = sub_idx_q;
    if (slot_end) begin
      sub_tick_d = '0;
      sub_idx_d  = '0;
    end else if (sub_tick_q == SUB_LAST) begin
      sub_tick_d = '0;
      sub_idx_d  = sub_idx_q + BRIGHT_W'(1);
    end else begin
      sub_tick_d = sub_tick_q + SUB_W'(1);
    end

    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    load_pending_d = 1'b0;
  end

  always_comb begin
    code_snap_d   = snap_en ? data_bus   : code_snap_q;
    dp_snap_d     = snap_en ? dp_mask    : dp_snap_q;
    blank_snap_d  = snap_en ? blank_mask : blank_snap_q;
    bright_snap_d = snap_en ? brightness : bright_snap_q;
  end

`ifdef SEG_BLINK_EN
  localparam int BCNT_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LOAD = BCNT_W'(BLINK_FRAMES - 1);

  logic [BCNT_W-1:0]     blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [NUM_DIGITS-1:0] blink_snap_q, blink_snap_d;

  // Down-counts frame boundaries; the phase flips on terminal count.
  always_comb begin
    blink_snap_d  = snap_en ? blink_mask : blink_snap_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_bnd) begin
      if (blink_cnt_q == '0) begin
        blink_cnt_d   = BCNT_LOAD;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q - BCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q   <= BCNT_LOAD;
      blink_phase_q <= 1'b0;
      blink_snap_q  <= '0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      blink_snap_q  <= blink_snap_d;
    end
  end

  assign blink_sup = blink_phase_q && blink_snap_q[idx_q];
`else
  assign blink_sup = 1'b0;
`endif

  assign code_sel = code_snap_q[{idx_q, 2'b00} +: 4];

  seg_glyph_dec u_glyph_dec (
    .code    (code_sel),
    .pattern (glyph_pat)
  );

  // tick_cnt == 0 is the anti-ghost gap: select lines switch while all dark.
  always_comb begin
    lit   = (tick_cnt_q != '0) && (sub_idx_q <= bright_snap_q) &&
            !blank_snap_q[idx_q] && !blink_sup;
    pos_d = lit ? (NUM_DIGITS'(1) << idx_q) : '0;
    seg_d = lit ? {dp_snap_q[idx_q], glyph_pat} : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q     <= '0;
      sub_tick_q     <= '0;
      sub_idx_q      <= '0;
      idx_q          <= '0;
      load_pending_q <= 1'b1;
      code_snap_q    <= '0;
      dp_snap_q      <= '0;
      blank_snap_q   <= '0;
      bright_snap_q  <= '0;
      pos_q          <= '0;
      seg_q          <= '0;
    end else begin
      tick_cnt_q     <= tick_cnt_d;
      sub_tick_q     <= sub_tick_d;
      sub_idx_q      <= sub_idx_d;
      idx_q          <= idx_d;
      load_pending_q <= load_pending_d;
      code_snap_q    <= code_snap_d;
      dp_snap_q      <= dp_snap_d;
      blank_snap_q   <= blank_snap_d;
      bright_snap_q  <= bright_snap_d;
      pos_q          <= pos_d;
      seg_q          <= seg_d;
    end
  end

  // Pin polarity applied after the registers; internal logic is always active-high.
  assign pos = ACTIVE_LOW ? ~pos_q : pos_q;
  assign seg = ACTIVE_LOW ? ~seg_q : seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8, BRIGHT_W=2.
// A second instance with ACTIVE_LOW=1 covers pin polarity.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_bus;
  logic [3:0]  dp_mask;
  logic [3:0]  blank_mask;
  logic [1:0]  brightness;
  logic [3:0]  pos;
  logic [7:0]  seg;
  logic        frame_start;
`ifdef SEG_BLINK_EN
  logic [3:0]  blink_mask;
  logic [3:0]  blink_mask_al;
`endif

  logic        rst_al;
  logic [15:0] data_al;
  logic [3:0]  mask_al;
  logic [1:0]  bright_al;
  logic [3:0]  pos_al;
  logic [7:0]  seg_al;
  logic        fs_al;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS(4), .SCAN_DIV(8), .BRIGHT_W(2), .ACTIVE_LOW(1'b0), .BLINK_FRAMES(2)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .data_bus    (data_bus),
    .dp_mask     (dp_mask),
    .blank_mask  (blank_mask),
    .brightness  (brightness),
`ifdef SEG_BLINK_EN
    .blink_mask  (blink_mask),
`endif
    .pos         (pos),
    .seg         (seg),
    .frame_start (frame_start)
  );

  seg_scan_ctrl #(
    .NUM_DIGITS(4), .SCAN_DIV(8), .BRIGHT_W(2), .ACTIVE_LOW(1'b1), .BLINK_FRAMES(2)
  ) u_dut_al (
    .clk         (clk),
    .rst         (rst_al),
    .data_bus    (data_al),
    .dp_mask     (mask_al),
    .blank_mask  (mask_al),
    .brightness  (bright_al),
`ifdef SEG_BLINK_EN
    .blink_mask  (blink_mask_al),
`endif
    .pos         (pos_al),
    .seg         (seg_al),
    .frame_start (fs_al)
  );

  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'h0: glyph = 7'b0111111;
      4'h1: glyph = 7'b0000110;
      4'h2: glyph = 7'b1011011;
      4'h3: glyph = 7'b1001111;
      4'h4: glyph = 7'b1100110;
      4'h5: glyph = 7'b1101101;
      4'h6: glyph = 7'b1111101;
      4'h7: glyph = 7'b0000111;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1101111;
      4'hA: glyph = 7'b0111110;
      4'hB: glyph = 7'b1011110;
      4'hC: glyph = 7'b1000000;
      4'hD: glyph = 7'b1110011;
      4'hE: glyph = 7'b0111001;
      default: glyph = 7'b0001000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observation after loop step (d,t) shows the output for tick t of digit slot d.
  task automatic test_reset();
    logic [15:0] exp_data;
    logic [3:0]  exp_pos;
    logic [7:0]  exp_seg;
    logic        exp_fs;
    exp_data   = 16'h4321;
    rst        = 1'b1;
    data_bus   = exp_data;
    brightness = 2'd3;
    dp_mask    = 4'b0;
    blank_mask = 4'b0;
    repeat (3) step();
    checks++;
    if (pos !== 4'b0 || seg !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs pos=%b seg=%h expected pos=0000 seg=00", pos, seg);
    end
    checks++;
    if (frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_frame_start got=%b expected=0", frame_start);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL release_frame_start got=%b expected=1", frame_start);
    end
    for (int d = 0; d < 4; d++) begin
      for (int t = 0; t < 8; t++) begin
        step();
        exp_pos = (t != 0) ? (4'b0001 << d) : 4'b0;
        exp_seg = (t != 0) ? {1'b0, glyph(exp_data[4*d +: 4])} : 8'h00;
        exp_fs  = (d == 3 && t == 6);
        checks++;
        if (pos !== exp_pos || seg !== exp_seg) begin
          errors++;
          $display("FAIL reset_frame d%0d t%0d pos=%b seg=%h expected pos=%b seg=%h",
                   d, t, pos, seg, exp_pos, exp_seg);
        end
        checks++;
        if (frame_start !== exp_fs) begin
          errors++;
          $display("FAIL reset_frame_fs d%0d t%0d got=%b expected=%b", d, t, frame_start, exp_fs);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    logic [15:0] exp_data;
    logic [3:0]  exp_pos;
    logic [7:0]  exp_seg;
    logic        exp_fs;
    for (int f = 0; f < 2; f++) begin
      exp_data = (f == 0) ? 16'h4321 : 16'h9999;
      for (int d = 0; d < 4; d++) begin
        for (int t = 0; t < 8; t++) begin
          if (f == 0 && d == 1 && t == 0) data_bus = 16'h9999;
          step();
          exp_pos = (t != 0) ? (4'b0001 << d) : 4'b0;
          exp_seg = (t != 0) ? {1'b0, glyph(exp_data[4*d +: 4])} : 8'h00;
          exp_fs  = (d == 3 && t == 6);
          checks++;
          if (pos !== exp_pos || seg !== exp_seg) begin
            errors++;
            $display("FAIL snapshot f%0d d%0d t%0d pos=%b seg=%h expected pos=%b seg=%h",
                     f, d, t, pos, seg, exp_pos, exp_seg);
          end
          checks++;
          if (frame_start !== exp_fs) begin
            errors++;
            $display("FAIL snapshot_fs f%0d d%0d t%0d got=%b expected=%b", f, d, t, frame_start, exp_fs);
          end
        end
      end
    end
  endtask

  // Brightness b lights ticks 1 .. 2b+1 of each 8-tick slot.
  task automatic test_brightness();
    logic [1:0]  b;
    logic        lit;
    logic [3:0]  exp_pos;
    logic [7:0]  exp_seg;
    int          lit_cnt;
    brightness = 2'd0;
    repeat (32) step();
    brightness = 2'd1;
    for (int f = 0; f < 2; f++) begin
      b = (f == 0) ? 2'd0 : 2'd1;
      if (f == 1) brightness = 2'd3;
      for (int d = 0; d < 4; d++) begin
        lit_cnt = 0;
        for (int t = 0; t < 8; t++) begin
          step();
          lit     = (t >= 1) && (t <= 2 * int'(b) + 1);
          exp_pos = lit ? (4'b0001 << d) : 4'b0;
          exp_seg = lit ? {1'b0, glyph(4'h9)} : 8'h00;
          if (pos != 4'b0) lit_cnt++;
          checks++;
          if (pos !== exp_pos || seg !== exp_seg) begin
            errors++;
            $display("FAIL brightness b%0d d%0d t%0d pos=%b seg=%h expected pos=%b seg=%h",
                     b, d, t, pos, seg, exp_pos, exp_seg);
          end
        end
        checks++;
        if (lit_cnt != 2 * int'(b) + 1) begin
          errors++;
          $display("FAIL brightness_count b%0d d%0d got=%0d expected=%0d", b, d, lit_cnt, 2 * int'(b) + 1);
        end
      end
    end
  endtask

  task automatic test_masks();
    logic [15:0] exp_data;
    logic        lit;
    logic [3:0]  exp_pos;
    logic [7:0]  exp_seg;
    exp_data   = 16'h4321;
    data_bus   = exp_data;
    blank_mask = 4'b0100;
    dp_mask    = 4'b0001;
    repeat (32) step();
    blank_mask = 4'b0;
    dp_mask    = 4'b0;
    for (int d = 0; d < 4; d++) begin
      for (int t = 0; t < 8; t++) begin
        step();
        lit     = (t != 0) && (d != 2);
        exp_pos = lit ? (4'b0001 << d) : 4'b0;
        exp_seg = lit ? {(d == 0), glyph(exp_data[4*d +: 4])} : 8'h00;
        checks++;
        if (pos !== exp_pos || seg !== exp_seg) begin
          errors++;
          $display("FAIL masks d%0d t%0d pos=%b seg=%h expected pos=%b seg=%h",
                   d, t, pos, seg, exp_pos, exp_seg);
        end
      end
    end
  endtask

  task automatic test_glyphs();
    logic [15:0] vec [4];
    logic [3:0]  exp_pos;
    logic [7:0]  exp_seg;
    vec[0] = 16'h3210;
    vec[1] = 16'h7654;
    vec[2] = 16'hBA98;
    vec[3] = 16'hFEDC;
    data_bus = vec[0];
    repeat (32) step();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) data_bus = vec[k+1];
      for (int d = 0; d < 4; d++) begin
        for (int t = 0; t < 8; t++) begin
          step();
          exp_pos = (t != 0) ? (4'b0001 << d) : 4'b0;
          exp_seg = (t != 0) ? {1'b0, glyph(vec[k][4*d +: 4])} : 8'h00;
          checks++;
          if (pos !== exp_pos || seg !== exp_seg) begin
            errors++;
            $display("FAIL glyph code=%h t%0d pos=%b seg=%h expected pos=%b seg=%h",
                     vec[k][4*d +: 4], t, pos, seg, exp_pos, exp_seg);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_slot();
    logic [15:0] exp_data;
    logic [3:0]  exp_pos;
    logic [7:0]  exp_seg;
    exp_data = 16'h8888;
    data_bus = exp_data;
    repeat (11) step();
    checks++;
    if (pos !== 4'b0010 || seg !== 8'h73) begin
      errors++;
      $display("FAIL pre_reset_lit pos=%b seg=%h expected pos=0010 seg=73", pos, seg);
    end
    rst = 1'b1;
    step();
    checks++;
    if (pos !== 4'b0 || seg !== 8'h00 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset pos=%b seg=%h fs=%b expected pos=0000 seg=00 fs=0", pos, seg, frame_start);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_release_fs got=%b expected=1", frame_start);
    end
    for (int d = 0; d < 4; d++) begin
      for (int t = 0; t < 8; t++) begin
        step();
        exp_pos = (t != 0) ? (4'b0001 << d) : 4'b0;
        exp_seg = (t != 0) ? {1'b0, glyph(exp_data[4*d +: 4])} : 8'h00;
        checks++;
        if (pos !== exp_pos || seg !== exp_seg) begin
          errors++;
          $display("FAIL post_reset d%0d t%0d pos=%b seg=%h expected pos=%b seg=%h",
                   d, t, pos, seg, exp_pos, exp_seg);
        end
      end
    end
  endtask

  task automatic test_active_low();
    logic [3:0] exp_pos;
    logic [7:0] exp_seg;
    data_al = 16'h000C;
    step();
    checks++;
    if (pos_al !== 4'b1111 || seg_al !== 8'hFF) begin
      errors++;
      $display("FAIL active_low_reset pos=%b seg=%h expected pos=1111 seg=ff", pos_al, seg_al);
    end
    rst_al = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < 8; t++) begin
        step();
        exp_pos = (t != 0) ? ~(4'b0001 << d) : 4'b1111;
        exp_seg = (t == 0) ? 8'hFF : ((d == 0) ? 8'b1011_1111 : 8'b1100_0000);
        checks++;
        if (pos_al !== exp_pos || seg_al !== exp_seg) begin
          errors++;
          $display("FAIL active_low d%0d t%0d pos=%b seg=%b expected pos=%b seg=%b",
                   d, t, pos_al, seg_al, exp_pos, exp_seg);
        end
      end
    end
  endtask

`ifdef SEG_BLINK_EN
  task automatic test_blink();
    logic [15:0] exp_data;
    logic        lit;
    logic [3:0]  exp_pos;
    logic [7:0]  exp_seg;
    exp_data   = 16'h4321;
    data_bus   = exp_data;
    brightness = 2'd3;
    blink_mask = 4'b0001;
    rst        = 1'b1;
    step();
    rst = 1'b0;
    #1;
    for (int f = 0; f < 6; f++) begin
      for (int d = 0; d < 4; d++) begin
        for (int t = 0; t < 8; t++) begin
          step();
          lit     = (t != 0) && !(d == 0 && (f == 2 || f == 3));
          exp_pos = lit ? (4'b0001 << d) : 4'b0;
          exp_seg = lit ? {1'b0, glyph(exp_data[4*d +: 4])} : 8'h00;
          checks++;
          if (pos !== exp_pos || seg !== exp_seg) begin
            errors++;
            $display("FAIL blink f%0d d%0d t%0d pos=%b seg=%h expected pos=%b seg=%h",
                     f, d, t, pos, seg, exp_pos, exp_seg);
          end
        end
      end
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    rst_al    = 1'b1;
    data_al   = 16'h0000;
    mask_al   = 4'b0;
    bright_al = 2'd3;
`ifdef SEG_BLINK_EN
    blink_mask    = 4'b0;
    blink_mask_al = 4'b0;
`endif
    test_reset();
    test_snapshot();
    test_brightness();
    test_masks();
    test_glyphs();
    test_reset_mid_slot();
    test_active_low();
`ifdef SEG_BLINK_EN
    test_blink();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Parametrised multiplexed 7-segment scan controller, the successor to the fixed 4-digit scanner.
- Drives NUM_DIGITS common-select lines and one shared 8-bit segment bus from the system clock.
- Integrated scan prescaler, tear-free per-frame snapshot, per-digit blank and decimal point, PWM brightness, anti-ghost dead time, selectable output polarity.
- Sits between the elevator controller's display bus and the board pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=1)
SCAN_DIV, 262144, clocks per digit slot; must be a multiple of 2**BRIGHT_W
BRIGHT_W, 3, brightness code width
ACTIVE_LOW, 0, 1 inverts pos and seg at the pins
BLINK_FRAMES, 32, frames per blink half-period (used only with SEG_BLINK_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
data_bus  in  4*NUM_DIGITS  glyph code per digit; digit i = data_bus[4i+3:4i]
dp_mask  in  NUM_DIGITS  decimal point on per digit
blank_mask  in  NUM_DIGITS  1 = digit dark
brightness  in  BRIGHT_W  duty code; 0 = 1/2**BRIGHT_W, max = full on
blink_mask  in  NUM_DIGITS  present only with SEG_BLINK_EN
pos  out  NUM_DIGITS  one-hot digit select (logical 1 = on before polarity)
seg  out  8  segments {dp,g,f,e,d,c,b,a}
frame_start  out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset is synchronous and active-high on clk. During and after reset:
  - tick_cnt=0, idx=0, sub_idx=0, frame_start=0.
  - pos and seg are inactive: all 0 logical, so all 1 at the pins if ACTIVE_LOW.
  - load_pending is set.
- Prescaler:
  - tick_cnt counts 0..SCAN_DIV-1; slot_end = (tick_cnt==SCAN_DIV-1).
  - SUB_LEN = SCAN_DIV>>BRIGHT_W.
  - sub_idx = tick_cnt / SUB_LEN, derived with a sub-counter, not a divider.
- Digit index: idx advances on slot_end and wraps NUM_DIGITS-1 -> 0.
- Snapshot:
  - data_bus, dp_mask, blank_mask and brightness are captured into shadow registers in either of two cycles:
    - the first non-reset cycle after reset (load_pending), or
    - the cycle with slot_end && idx==NUM_DIGITS-1 (frame boundary).
  - frame_start pulses in that same cycle.
  - Input changes mid-frame are ignored until the next frame.
- Output stage is fully registered, 1-cycle latency from counter state. Digit idx is lit when all of these hold:
  - tick_cnt != 0 (one-clock dead time at every slot start, anti-ghost);
  - sub_idx <= brightness_snap;
  - !blank_snap[idx];
  - not blink-suppressed.
- When lit: pos = 1<<idx, seg[6:0] = decode(code_snap[idx]), seg[7] = dp_snap[idx].
- When not lit: pos=0, seg=0 (logical).
- Decode table, bits g..a:
  - 0-9 are standard digits: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - A="U" 0111110, B="d" 1011110, C="-" 1000000, D="P" 1110011, E="C" 0111001, F="_" 0001000.
- ACTIVE_LOW=1 inverts pos and seg after the output registers; internal logic is unchanged.
- Reset asserted mid-slot: pos/seg go inactive on the next clk edge, and the first post-reset frame starts from idx=0 with a fresh snapshot.
- NUM_DIGITS=1: idx stays 0 and every slot_end is a frame boundary.
- Elaboration error if SCAN_DIV%2**BRIGHT_W!=0 or SUB_LEN<2.

Optional Feature:
SEG_BLINK_EN
- Defined:
  - blink_mask port exists and is snapshotted with the other inputs.
  - A frame counter toggles blink_phase every BLINK_FRAMES frames; reset value is 0.
  - While blink_phase=1, digits with blink_mask_snap set are dark.
- Undefined: no blink_mask port, no frame counter; never blink-suppressed.

Decomposition:
- Package seg_pkg holds:
  - the glyph code constants (GLY_U=4'hA, GLY_D=4'hB, GLY_DASH=4'hC, GLY_OPEN=4'hD, GLY_CLOSE=4'hE, GLY_BAR=4'hF);
  - the 7-bit segment patterns as constants.
- One sub-module, seg_glyph_dec: purely combinational 4-bit code -> 7-bit pattern, instantiated once on the muxed snapshot code.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, BRIGHT_W=2 unless noted.
- Reset release with data_bus=16'h4321, brightness=3:
  - frame_start pulses on the first cycle;
  - pos stays 0 for cycle 1 (dead time);
  - then pos=0001, seg=0000_0110 for 7 cycles;
  - then digits 2/3/4 show 2/3/4 in turn.
- Change data_bus to 16'h9999 mid-frame at idx=1: digits 1-3 keep 2/3/4; 9s appear only after the next frame_start.
- brightness=0: each digit lit only while sub_idx==0, i.e. 1 of 8 clocks (tick_cnt==1); pos=0 otherwise. brightness=1 gives 3 lit clocks.
- blank_mask=4'b0100, dp_mask=4'b0001: digit 2 slot all pos=0/seg=0; digit 0 shows seg[7]=1.
- Rebuild with ACTIVE_LOW=1 and hold rst: pos=4'b1111, seg=8'hFF; code 4'hC on digit 0 gives seg=8'b1011_1111.
- With SEG_BLINK_EN, BLINK_FRAMES=2, blink_mask=4'b0001: digit 0 lit for 2 frames, dark for 2, repeating. Other digits are unaffected.
